// File: rtl/bram_tdp_param.sv
// Parametrised true-dual-port block RAM: per-lane write enables, per-port write mode,
// optional output register stage. Define BRAM_COLLISION_CHECK_EN to build collision detection/counting.
module bram_tdp_param #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 9,
   parameter int unsigned DEPTH        = 512,
   parameter int unsigned BYTE_W       = 8,
   parameter int unsigned WRITE_MODE_A = 0,
   parameter int unsigned WRITE_MODE_B = 0,
   parameter int unsigned OUT_REG      = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic [DATA_W/BYTE_W-1:0]   wea,
   input  logic [ADDR_W-1:0]          addra,
   input  logic [DATA_W-1:0]          dia,
   output logic [DATA_W-1:0]          doa,
   output logic                       dva,
   input  logic                       enb,
   input  logic [DATA_W/BYTE_W-1:0]   web,
   input  logic [ADDR_W-1:0]          addrb,
   input  logic [DATA_W-1:0]          dib,
   output logic [DATA_W-1:0]          dob,
   output logic                       dvb,
   output logic                       collision,
   output logic [15:0]                coll_cnt
);

   localparam int unsigned NB       = DATA_W / BYTE_W;
   localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned MODE_WF  = 0;
   localparam int unsigned MODE_RF  = 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   // Overlay the enabled lanes of din onto base.
   function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] base,
                                                    input logic [DATA_W-1:0] din,
                                                    input logic [NB-1:0]     we);
      logic [DATA_W-1:0] res;
      res = base;
      for (int i = 0; i < int'(NB); i++) begin
         if (we[i]) res[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
      end
      return res;
   endfunction

   // Low through reset and for the first edge after release, so that edge is ignored.
   logic run_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) run_q <= 1'b0;
      else        run_q <= 1'b1;
   end

   logic              acc_a, acc_b, wr_a, wr_b, in_a, in_b, same_addr;
   logic [IW-1:0]     idx_a, idx_b;
   logic [DATA_W-1:0] old_a, old_b, new_a, new_b, wdat_a;

   assign acc_a     = run_q & ena;
   assign acc_b     = run_q & enb;
   assign wr_a      = acc_a & (|wea);
   assign wr_b      = acc_b & (|web);
   assign in_a      = {1'b0, addra} < DEPTH_L;
   assign in_b      = {1'b0, addrb} < DEPTH_L;
   assign idx_a     = addra[IW-1:0];
   assign idx_b     = addrb[IW-1:0];
   assign same_addr = in_a & in_b & (addra == addrb);
   assign old_a     = in_a ? mem[idx_a] : '0;
   assign old_b     = in_b ? mem[idx_b] : '0;
   assign new_a     = lane_merge(old_a, dia, wea);
   assign new_b     = lane_merge(old_b, dib, web);
   // On a double write to one word, port A lanes overlay port B's merged word.
   assign wdat_a    = lane_merge((wr_b & same_addr) ? new_b : old_a, dia, wea);

   // Memory array: not reset; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (wr_a && in_a) mem[idx_a] <= wdat_a;
      if (wr_b && in_b && !(wr_a && same_addr)) mem[idx_b] <= new_b;
   end

   logic [DATA_W-1:0] do1_a, do1_b;
   logic              dv1_a, dv1_b;

   // Port A first stage; no_change writes hold data and drop valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         do1_a <= '0;
         dv1_a <= 1'b0;
      end else begin
         dv1_a <= 1'b0;
         if (acc_a) begin
            if (!wr_a || WRITE_MODE_A == MODE_RF) begin
               do1_a <= old_a;
               dv1_a <= 1'b1;
            end else if (WRITE_MODE_A == MODE_WF) begin
               do1_a <= new_a;
               dv1_a <= 1'b1;
            end
         end
      end
   end

   // Port B first stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         do1_b <= '0;
         dv1_b <= 1'b0;
      end else begin
         dv1_b <= 1'b0;
         if (acc_b) begin
            if (!wr_b || WRITE_MODE_B == MODE_RF) begin
               do1_b <= old_b;
               dv1_b <= 1'b1;
            end else if (WRITE_MODE_B == MODE_WF) begin
               do1_b <= new_b;
               dv1_b <= 1'b1;
            end
         end
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] do2_a, do2_b;
      logic              dv2_a, dv2_b;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            do2_a <= '0;
            do2_b <= '0;
            dv2_a <= 1'b0;
            dv2_b <= 1'b0;
         end else begin
            do2_a <= do1_a;
            do2_b <= do1_b;
            dv2_a <= dv1_a;
            dv2_b <= dv1_b;
         end
      end
      assign doa = do2_a;
      assign dob = do2_b;
      assign dva = dv2_a;
      assign dvb = dv2_b;
   end else begin : g_no_out_reg
      assign doa = do1_a;
      assign dob = do1_b;
      assign dva = dv1_a;
      assign dvb = dv1_b;
   end

`ifdef BRAM_COLLISION_CHECK_EN
   logic        coll_c;
   logic        collision_q;
   logic [15:0] coll_cnt_q;

   assign coll_c = acc_a & acc_b & same_addr & (wr_a | wr_b);

   // Collision flag and saturating counter, both registered on the colliding edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collision_q <= 1'b0;
         coll_cnt_q  <= '0;
      end else begin
         collision_q <= coll_c;
         if (coll_c) begin
            $display("bram_tdp_param: collision addr=%h", addra);
            if (coll_cnt_q != 16'hFFFF) coll_cnt_q <= coll_cnt_q + 16'd1;
         end
      end
   end

   assign collision = collision_q;
   assign coll_cnt  = coll_cnt_q;
`else
   assign collision = 1'b0;
   assign coll_cnt  = '0;
`endif

endmodule
